// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and sequential program loader: assembles one
// instruction per handshake from class + fields and writes it to consecutive words.
module instr_encoder_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          InValid,
    output logic          InReady,
    input  logic [2:0]    InstType,
    input  logic [4:0]    Rd,
    input  logic [4:0]    Rs1,
    input  logic [4:0]    Rs2,
    input  logic [2:0]    Funct3,
    input  logic [6:0]    Funct7,
    input  logic [31:0]   Imm,
    input  logic          Clear,
    output logic          MemWE,
    output logic [31:0]   MemAddr,
    output logic [31:0]   MemData,
    output logic [CW-1:0] Count,
    output logic          Full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] count_r;
    logic [31:0]   addr_r;
    logic [31:0]   data_r;
    logic [31:0]   enc_s;
    logic          accept_s;

    // Unused fields of a class stay zero; classes with a fixed funct3 ignore Funct3.
    function automatic logic [31:0] encode(
        input logic [2:0]  t,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (t)
            3'd0: w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            3'd1: w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            3'd2: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            3'd3: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            3'd4: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    w = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
                end
            end
            3'd5: w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            3'd6: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            3'd7: w = {imm[31:12], rd, 7'b0110111};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Combinational encode and handshake qualification.
    always_comb begin
        enc_s    = encode(InstType, Rd, Rs1, Rs2, Funct3, Funct7, Imm);
        accept_s = (state_r == IDLE) && InValid && !Clear;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; Clear wins over every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (Clear) begin
                    state_next_s = IDLE;
                end else if (count_r == LAST_C) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FULL: begin
                if (Clear) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Count and address advance together when a write completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            addr_r  <= BASE_ADDR;
            data_r  <= 32'd0;
        end else begin
            if (Clear) begin
                count_r <= {CW{1'b0}};
                addr_r  <= BASE_ADDR;
            end else if (state_r == WRITE) begin
                count_r <= count_r + CW'(1'b1);
                addr_r  <= addr_r + 32'd4;
            end
            if (accept_s) begin
                data_r <= enc_s;
            end
        end
    end

    // Output decode from state.
    always_comb begin
        InReady = 1'b0;
        MemWE   = 1'b0;
        Full    = 1'b0;
        case (state_r)
            IDLE:    InReady = !Clear;
            WRITE:   MemWE   = 1'b1;
            FULL:    Full    = 1'b1;
            default: InReady = 1'b0;
        endcase
    end

    assign MemAddr = addr_r;
    assign MemData = data_r;
    assign Count   = count_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed vectors plus randomized
// bundles checked against an arithmetic RV32I encoding model.
module tb_instr_encoder_loader;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          InValid;
    logic          InReady;
    logic [2:0]    InstType;
    logic [4:0]    Rd;
    logic [4:0]    Rs1;
    logic [4:0]    Rs2;
    logic [2:0]    Funct3;
    logic [6:0]    Funct7;
    logic [31:0]   Imm;
    logic          Clear;
    logic          MemWE;
    logic [31:0]   MemAddr;
    logic [31:0]   MemData;
    logic [CW-1:0] Count;
    logic          Full;

    int checks = 0;
    int passed = 0;
    int exp_count = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .InstType(InstType), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .Funct3(Funct3), .Funct7(Funct7), .Imm(Imm), .Clear(Clear),
        .MemWE(MemWE), .MemAddr(MemAddr), .MemData(MemData),
        .Count(Count), .Full(Full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Model: opcode plus each field shifted into its bit position.
    function automatic logic [31:0] ref_enc(input int unsigned t, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int unsigned f3, input int unsigned f7,
                                             input int unsigned imm);
        int unsigned w;
        case (t)
            0: w = 51  | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
            1: w = 3   | (rd << 7) | (2 << 12) | (rs1 << 15) | ((imm & 4095) << 20);
            2: w = 35  | ((imm & 31) << 7) | (2 << 12) | (rs1 << 15) | (rs2 << 20)
                       | (((imm >> 5) & 127) << 25);
            3: w = 99  | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12)
                       | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 63) << 25)
                       | (((imm >> 12) & 1) << 31);
            4: begin
                if (f3 == 1 || f3 == 5)
                    w = 19 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (f7 << 25);
                else
                    w = 19 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 4095) << 20);
            end
            5: w = 103 | (rd << 7) | (rs1 << 15) | ((imm & 4095) << 20);
            6: w = 111 | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                       | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
            default: w = 55 | (rd << 7) | (imm & 32'hFFFF_F000);
        endcase
        return w;
    endfunction

    function automatic logic [31:0] cur_enc();
        return ref_enc(InstType, Rd, Rs1, Rs2, Funct3, Funct7, Imm);
    endfunction

    task automatic rand_fields();
        InstType = 3'($urandom_range(7, 0));
        Rd       = 5'($urandom);
        Rs1      = 5'($urandom);
        Rs2      = 5'($urandom);
        Funct3   = 3'($urandom);
        Funct7   = 7'($urandom);
        Imm      = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    MemWE,   32'd0);
        check({tag, "_data"},  MemData, 32'd0);
        check({tag, "_addr"},  MemAddr, BASE);
        check({tag, "_count"}, Count,   32'd0);
        check({tag, "_full"},  Full,    32'd0);
        check({tag, "_ready"}, InReady, 32'd1);
    endtask

    // Drives one bundle through a complete handshake and checks the write.
    task automatic send(input string tag, input logic [2:0] t, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp_w);
        int n;
        @(negedge clk);
        InstType = t; Rd = rd; Rs1 = rs1; Rs2 = rs2; Funct3 = f3; Funct7 = f7; Imm = imm;
        InValid = 1'b1;
        #1;
        n = 0;
        while (!InReady && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        rand_fields();
        check({tag, "_we"},    MemWE,   32'd1);
        check({tag, "_addr"},  MemAddr, BASE + 32'(4 * exp_count));
        check({tag, "_data"},  MemData, exp_w);
        check({tag, "_busy"},  InReady, 32'd0);
        @(posedge clk);
        #1;
        exp_count++;
        check({tag, "_count"}, Count,   32'(exp_count));
        check({tag, "_we_off"}, MemWE,  32'd0);
        check({tag, "_full"},  Full,    32'(exp_count == DEPTH));
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        Clear = 1'b1;
        #1;
        check({tag, "_ready"}, InReady, 32'd0);
        @(posedge clk);
        #1;
        Clear = 1'b0;
        exp_count = 0;
        check({tag, "_count"}, Count,   32'd0);
        check({tag, "_addr"},  MemAddr, BASE);
        check({tag, "_full"},  Full,    32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic        we_exp;
        rst = 1'b1; InValid = 1'b0; Clear = 1'b0;
        InstType = 3'd0; Rd = 5'd0; Rs1 = 5'd0; Rs2 = 5'd0;
        Funct3 = 3'd0; Funct7 = 7'd0; Imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Directed vectors from known RV32I encodings.
        send("r_add", 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
        do_clear("clr1");
        send("lw", 3'd1, 5'd5, 5'd2, 5'd0, 3'd7, 7'd0, 32'd8, 32'h00812283);
        send("sw", 3'd2, 5'd0, 5'd2, 5'd6, 3'd5, 7'd0, 32'd12, 32'h00612623);
        do_clear("clr2");
        send("beq", 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE208EE3);
        send("jal", 3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h010000EF);
        send("lui", 3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h123452B7);
        do_clear("clr3");

        // Clear and InValid together in IDLE: nothing accepted.
        @(negedge clk);
        InValid = 1'b1; Clear = 1'b1;
        #1;
        check("clr_valid_ready", InReady, 32'd0);
        @(posedge clk);
        #1;
        InValid = 1'b0; Clear = 1'b0;
        check("clr_valid_we", MemWE, 32'd0);
        check("clr_valid_count", Count, 32'd0);

        // InValid held high: a write every other cycle until full.
        w = 32'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rand_fields();
            InValid = 1'b1;
            if (k % 2 == 0) w = cur_enc();
            @(posedge clk);
            #1;
            we_exp = (k % 2 == 0) && (k < 8);
            check("fill_we", MemWE, 32'(we_exp));
            if (we_exp) begin
                check("fill_addr", MemAddr, BASE + 32'(4 * (k / 2)));
                check("fill_data", MemData, w);
            end
        end
        InValid = 1'b0;
        exp_count = DEPTH;
        check("full_flag", Full, 32'd1);
        check("full_ready", InReady, 32'd0);
        check("full_count", Count, 32'(DEPTH));
        do_clear("clr_full");
        send("after_full", 3'd4, 5'd9, 5'd4, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF20493);

        // Reset while a write is in progress.
        @(negedge clk);
        rand_fields();
        InValid = 1'b1;
        @(posedge clk);
        #1;
        InValid = 1'b0;
        check("rst_write_we", MemWE, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_write");
        rst = 1'b0;
        exp_count = 0;

        // Randomized bundles with occasional clears.
        for (int i = 0; i < 24; i++) begin
            if (exp_count == DEPTH || $urandom_range(5, 0) == 0) do_clear("rnd_clr");
            rand_fields();
            w = cur_enc();
            send("rnd", InstType, Rd, Rs1, Rs2, Funct3, Funct7, Imm, w);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
